rv_timer_ctrl: RTL and testbench

RV_TIMER_CTRL -- requirements
Module: rv_timer_ctrl

---
 rtl/rv_timer_ctrl_pkg.sv | 30 +++
 rtl/rv_timer_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_rv_timer_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_timer_ctrl_pkg.sv
// rv_timer_ctrl_pkg
// Shared definitions for the RISC-V timer register controller:
//   - byte offsets of the register map
//   - reset values for the configuration and comparator registers
//   - state enum of the write-staging FSM used for 64-bit register writes
package rv_timer_ctrl_pkg;

  // Register map, byte offsets within the 9-bit register window
  localparam logic [8:0] ADDR_CTRL     = 9'h000;
  localparam logic [8:0] ADDR_CFG      = 9'h004;
  localparam logic [8:0] ADDR_INTR_EN  = 9'h008;
  localparam logic [8:0] ADDR_MTIME_LO = 9'h00C;
  localparam logic [8:0] ADDR_MTIME_HI = 9'h010;
  localparam logic [8:0] ADDR_CMP_BASE = 9'h100;

  // Comparator i lives at ADDR_CMP_BASE + 8*i (low) and +4 on top of that (high)
  localparam int MAX_HARTS = 8;

  // Reset values
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [7:0]  STEP_RST     = 8'd1;

  // Write-staging FSM: a low-half write is held until the matching high half
  typedef enum logic [1:0] {
    ST_IDLE          = 2'd0,
    ST_MT_LO_STAGED  = 2'd1,
    ST_CMP_LO_STAGED = 2'd2
  } stage_state_e;

endpackage

// File: rtl/rv_timer_ctrl.sv
// rv_timer_ctrl
// Register front end for a RISC-V machine timer. Holds the control/config
// registers, the 64-bit mtime value and N 64-bit mtimecmp comparators, and
// gates the raw comparator interrupts coming back from the timer core.
// 64-bit registers are written as LO then HI; the LO half is staged and the
// full value is committed atomically on the HI write.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   reg_we, reg_re          single-cycle write / read strobes
//   reg_addr, reg_wdata     word-aligned byte address, write data
//   reg_rdata, reg_rvalid   read data, valid one cycle after reg_re
//   reg_error               bad access (unmapped, we+re, comparator >= N)
//   active, prescaler, step configuration to the timer core
//   tick, mtime_d           core says "load mtime_d now"
//   mtime, mtimecmp         current time and comparators to the core
//   intr_raw, intr_o        raw compare hits in, enabled/masked interrupts out
module rv_timer_ctrl
  import rv_timer_ctrl_pkg::*;
#(
  parameter int N = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 reg_we,
  input  logic                 reg_re,
  input  logic [8:0]           reg_addr,
  input  logic [31:0]          reg_wdata,
  output logic [31:0]          reg_rdata,
  output logic                 reg_rvalid,
  output logic                 reg_error,
  output logic                 active,
  output logic [11:0]          prescaler,
  output logic [7:0]           step,
  input  logic                 tick,
  input  logic [63:0]          mtime_d,
  output logic [63:0]          mtime,
  output logic [N-1:0][63:0]   mtimecmp,
  input  logic [N-1:0]         intr_raw,
  output logic [N-1:0]         intr_o
);

  // Architectural registers
  logic                 r_active;
  logic [11:0]          r_prescaler;
  logic [7:0]           r_step;
  logic [N-1:0]         r_intrEn;
  logic [63:0]          r_mtime;
  logic [N-1:0][63:0]   r_mtimecmp;

  // Staging and read-coherency state
  stage_state_e         r_state;
  stage_state_e         w_stateNext;
  logic [31:0]          r_stage;
  logic [2:0]           r_stageIdx;
  logic [31:0]          r_shadow;
  logic                 r_shadowValid;

  // Registered read response
  logic [31:0]          r_rdata;
  logic                 r_rvalid;
  logic                 r_error;

  // Decode
  logic                 w_isCtrl;
  logic                 w_isCfg;
  logic                 w_isIntrEn;
  logic                 w_isMtLo;
  logic                 w_isMtHi;
  logic                 w_cmpRegion;
  logic [2:0]           w_cmpIdx;
  logic                 w_cmpHi;
  logic                 w_cmpValid;
  logic                 w_isCmpLo;
  logic                 w_isCmpHi;
  logic                 w_mapped;
  logic                 w_err;
  logic                 w_wrOk;
  logic                 w_rdOk;
  logic                 w_mtHiCommit;
  logic [31:0]          w_rdataNext;
  logic [N-1:0]         w_mask;

  // Address decode. Comparators occupy 0x100..0x13F; bits [5:3] are the index
  // and bit 2 selects the high half. Indices >= N decode as unmapped.
  always_comb begin
    w_isCtrl    = (reg_addr == ADDR_CTRL);
    w_isCfg     = (reg_addr == ADDR_CFG);
    w_isIntrEn  = (reg_addr == ADDR_INTR_EN);
    w_isMtLo    = (reg_addr == ADDR_MTIME_LO);
    w_isMtHi    = (reg_addr == ADDR_MTIME_HI);
    w_cmpRegion = (reg_addr[8:6] == ADDR_CMP_BASE[8:6]) && (reg_addr[1:0] == 2'b00);
    w_cmpIdx    = reg_addr[5:3];
    w_cmpHi     = reg_addr[2];
    w_cmpValid  = w_cmpRegion && (int'(w_cmpIdx) < N);
    w_isCmpLo   = w_cmpValid && !w_cmpHi;
    w_isCmpHi   = w_cmpValid && w_cmpHi;
    w_mapped    = w_isCtrl || w_isCfg || w_isIntrEn || w_isMtLo || w_isMtHi || w_cmpValid;
    // Simultaneous read and write is rejected outright and touches nothing
    w_err        = (reg_we && reg_re) || ((reg_we || reg_re) && !w_mapped);
    w_wrOk       = reg_we && !reg_re && w_mapped;
    w_rdOk       = reg_re && !reg_we && w_mapped;
    w_mtHiCommit = w_wrOk && w_isMtHi;
  end

  // Read data mux; unused bits are zero
  always_comb begin
    w_rdataNext = '0;
    if (w_isCtrl) begin
      w_rdataNext[0] = r_active;
    end else if (w_isCfg) begin
      w_rdataNext[11:0]  = r_prescaler;
      w_rdataNext[23:16] = r_step;
    end else if (w_isIntrEn) begin
      w_rdataNext[N-1:0] = r_intrEn;
    end else if (w_isMtLo) begin
      w_rdataNext = r_mtime[31:0];
    end else if (w_isMtHi) begin
      // Shadow gives a coherent 64-bit read across a carry into the high half
      w_rdataNext = r_shadowValid ? r_shadow : r_mtime[63:32];
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_cmpValid && (w_cmpIdx == 3'(i))) begin
          w_rdataNext = w_cmpHi ? r_mtimecmp[i][63:32] : r_mtimecmp[i][31:0];
        end
      end
    end
  end

  // FSM next state: only accepted writes move it. A LO write stages, anything
  // else (including the HI commit) lands back in IDLE and drops the stage.
  always_comb begin
    w_stateNext = r_state;
    if (w_wrOk) begin
      if (w_isMtLo) begin
        w_stateNext = ST_MT_LO_STAGED;
      end else if (w_isCmpLo) begin
        w_stateNext = ST_CMP_LO_STAGED;
      end else begin
        w_stateNext = ST_IDLE;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Register file, mtime, stage/shadow and the read response pipeline
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_active      <= 1'b0;
      r_prescaler   <= '0;
      r_step        <= STEP_RST;
      r_intrEn      <= '0;
      r_mtime       <= '0;
      for (int i = 0; i < N; i++) begin
        r_mtimecmp[i] <= MTIMECMP_RST;
      end
      r_stage       <= '0;
      r_stageIdx    <= '0;
      r_shadow      <= '0;
      r_shadowValid <= 1'b0;
      r_rdata       <= '0;
      r_rvalid      <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      if (w_wrOk && w_isCtrl) begin
        r_active <= reg_wdata[0];
      end
      if (w_wrOk && w_isCfg) begin
        r_prescaler <= reg_wdata[11:0];
        r_step      <= reg_wdata[23:16];
      end
      if (w_wrOk && w_isIntrEn) begin
        r_intrEn <= reg_wdata[N-1:0];
      end

      if (w_wrOk && (w_isMtLo || w_isCmpLo)) begin
        r_stage    <= reg_wdata;
        r_stageIdx <= w_cmpIdx;
      end

      // A HI commit overrides a same-cycle tick; that increment is lost
      if (w_mtHiCommit) begin
        r_mtime <= {reg_wdata, (r_state == ST_MT_LO_STAGED) ? r_stage : r_mtime[31:0]};
      end else if (tick && r_active) begin
        r_mtime <= mtime_d;
      end

      // Comparator HI commit uses the stage only if it was staged for this index
      for (int i = 0; i < N; i++) begin
        if (w_wrOk && w_isCmpHi && (w_cmpIdx == 3'(i))) begin
          r_mtimecmp[i] <= {reg_wdata,
                            ((r_state == ST_CMP_LO_STAGED) && (r_stageIdx == 3'(i)))
                              ? r_stage : r_mtimecmp[i][31:0]};
        end
      end

      if (w_wrOk && (w_isMtLo || w_isMtHi)) begin
        r_shadowValid <= 1'b0;
      end else if (w_rdOk && w_isMtLo) begin
        r_shadow      <= r_mtime[63:32];
        r_shadowValid <= 1'b1;
      end

      r_rvalid <= reg_re;
      r_error  <= w_err;
      r_rdata  <= w_rdOk ? w_rdataNext : '0;
    end
  end

  // Hold off a comparator's interrupt while its new value is half written
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N; i++) begin
      if ((r_state == ST_CMP_LO_STAGED) && (r_stageIdx == 3'(i))) begin
        w_mask[i] = 1'b1;
      end
    end
  end

  assign intr_o     = intr_raw & r_intrEn & ~w_mask;
  assign active     = r_active;
  assign prescaler  = r_prescaler;
  assign step       = r_step;
  assign mtime      = r_mtime;
  assign mtimecmp   = r_mtimecmp;
  assign reg_rdata  = r_rdata;
  assign reg_rvalid = r_rvalid;
  assign reg_error  = r_error;

endmodule

// File: tb/tb_rv_timer_ctrl.sv
// tb_rv_timer_ctrl
// Directed bench for rv_timer_ctrl (N=1). Register responses go through a
// scoreboard queue filled by the stimulus tasks and drained by a monitor on
// the falling edge; port-level values (mtime, mtimecmp, intr_o, config) are
// compared directly after each stimulus cycle. mtime_d models the core as
// mtime + step.
module tb_rv_timer_ctrl;
  import rv_timer_ctrl_pkg::*;

  localparam int NH = 1;

  logic                clk_i;
  logic                rst_i;
  logic                reg_we;
  logic                reg_re;
  logic [8:0]          reg_addr;
  logic [31:0]         reg_wdata;
  logic [31:0]         reg_rdata;
  logic                reg_rvalid;
  logic                reg_error;
  logic                active;
  logic [11:0]         prescaler;
  logic [7:0]          step;
  logic                tick;
  logic [63:0]         mtime_d;
  logic [63:0]         mtime;
  logic [NH-1:0][63:0] mtimecmp;
  logic [NH-1:0]       intr_raw;
  logic [NH-1:0]       intr_o;

  typedef struct packed {
    logic        rvalid;
    logic        err;
    logic [31:0] data;
    logic [8:0]  addr;
  } rsp_t;

  rsp_t expQ[$];
  int   total;
  int   bad;

  rv_timer_ctrl #(.N(NH)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .reg_rvalid(reg_rvalid),
    .reg_error (reg_error),
    .active    (active),
    .prescaler (prescaler),
    .step      (step),
    .tick      (tick),
    .mtime_d   (mtime_d),
    .mtime     (mtime),
    .mtimecmp  (mtimecmp),
    .intr_raw  (intr_raw),
    .intr_o    (intr_o)
  );

  // Core model: the next mtime is always current mtime plus step
  assign mtime_d = mtime + {56'd0, step};

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Monitor: every response the DUT presents must match the oldest expectation
  always @(negedge clk_i) begin
    if (reg_rvalid || reg_error) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_rsp: got rvalid=%0b error=%0b rdata=%h, expected no response",
                 reg_rvalid, reg_error, reg_rdata);
      end else begin
        rsp_t e;
        e = expQ.pop_front();
        if (reg_rvalid !== e.rvalid || reg_error !== e.err || reg_rdata !== e.data) begin
          bad++;
          $display("[TB] FAIL rsp@%h: got rvalid=%0b error=%0b rdata=%h, expected rvalid=%0b error=%0b rdata=%h",
                   e.addr, reg_rvalid, reg_error, reg_rdata, e.rvalid, e.err, e.data);
        end
      end
    end
  end

  // One bus cycle: drive, let the DUT sample it, then release the strobes
  task automatic applyStimulus(input logic we, input logic re, input logic [8:0] addr,
                               input logic [31:0] wdata, input logic tk);
    reg_we    = we;
    reg_re    = re;
    reg_addr  = addr;
    reg_wdata = wdata;
    tick      = tk;
    @(posedge clk_i);
    #1;
    reg_we = 1'b0;
    reg_re = 1'b0;
    tick   = 1'b0;
  endtask

  task automatic regWrite(input logic [8:0] addr, input logic [31:0] data,
                          input logic expErr, input logic tk);
    if (expErr) expQ.push_back('{rvalid: 1'b0, err: 1'b1, data: 32'd0, addr: addr});
    applyStimulus(1'b1, 1'b0, addr, data, tk);
  endtask

  task automatic regRead(input logic [8:0] addr, input logic [31:0] expData, input logic expErr);
    expQ.push_back('{rvalid: 1'b1, err: expErr, data: (expErr ? 32'd0 : expData), addr: addr});
    applyStimulus(1'b0, 1'b1, addr, 32'd0, 1'b0);
  endtask

  task automatic idleCycles(input int n, input logic tk);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, ADDR_CTRL, 32'd0, tk);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_active",    64'(active),      64'd0);
    checkOutput("rst_prescaler", 64'(prescaler),   64'd0);
    checkOutput("rst_step",      64'(step),        64'd1);
    checkOutput("rst_mtime",     mtime,            64'd0);
    checkOutput("rst_mtimecmp",  mtimecmp[0],      64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("rst_rvalid",    64'(reg_rvalid),  64'd0);
    checkOutput("rst_error",     64'(reg_error),   64'd0);
    checkOutput("rst_rdata",     64'(reg_rdata),   64'd0);
    checkOutput("rst_intr_o",    64'(intr_o),      64'd0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_i     = 1'b1;
    reg_we    = 1'b0;
    reg_re    = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    tick      = 1'b0;
    intr_raw  = '1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    checkResetState();

    // Reset values through the register interface
    regRead(ADDR_INTR_EN, 32'h0000_0000, 1'b0);
    regRead(ADDR_CFG, 32'h0001_0000, 1'b0);
    regRead(9'h104, 32'hFFFF_FFFF, 1'b0);

    // Config fields and unused bits
    regWrite(ADDR_CFG, 32'hFFFF_FFFF, 1'b0, 1'b0);
    regRead(ADDR_CFG, 32'h00FF_0FFF, 1'b0);
    checkOutput("cfg_prescaler", 64'(prescaler), 64'hFFF);
    checkOutput("cfg_step", 64'(step), 64'hFF);
    regWrite(ADDR_CFG, 32'h0001_0000, 1'b0, 1'b0);
    regWrite(ADDR_CTRL, 32'h0000_0001, 1'b0, 1'b0);
    regRead(ADDR_CTRL, 32'h0000_0001, 1'b0);
    regWrite(ADDR_CTRL, 32'h0000_0000, 1'b0, 1'b0);
    regRead(ADDR_CTRL, 32'h0000_0000, 1'b0);

    // Staged LO does not touch mtime; inactive timer ignores ticks
    regWrite(ADDR_MTIME_LO, 32'h89AB_CDEF, 1'b0, 1'b0);
    idleCycles(3, 1'b1);
    checkOutput("mt_staged_hold", mtime, 64'd0);
    regWrite(ADDR_MTIME_HI, 32'h0123_4567, 1'b0, 1'b0);
    checkOutput("mt_commit", mtime, 64'h0123_4567_89AB_CDEF);
    regRead(ADDR_MTIME_LO, 32'h89AB_CDEF, 1'b0);
    regRead(ADDR_MTIME_HI, 32'h0123_4567, 1'b0);

    // Unstaged HI keeps the live low half and invalidates the shadow
    regWrite(ADDR_MTIME_HI, 32'h0000_0009, 1'b0, 1'b0);
    checkOutput("mt_hi_unstaged", mtime, 64'h0000_0009_89AB_CDEF);
    regRead(ADDR_MTIME_HI, 32'h0000_0009, 1'b0);

    // Carry into the high half, read through the shadow
    regWrite(ADDR_CTRL, 32'h0000_0001, 1'b0, 1'b0);
    regWrite(ADDR_MTIME_LO, 32'hFFFF_FFFF, 1'b0, 1'b0);
    regWrite(ADDR_MTIME_HI, 32'h0000_0000, 1'b0, 1'b0);
    checkOutput("mt_pre_carry", mtime, 64'h0000_0000_FFFF_FFFF);
    idleCycles(1, 1'b1);
    checkOutput("mt_carry", mtime, 64'h0000_0001_0000_0000);
    regRead(ADDR_MTIME_LO, 32'h0000_0000, 1'b0);
    idleCycles(1, 1'b1);
    regRead(ADDR_MTIME_HI, 32'h0000_0001, 1'b0);
    checkOutput("mt_after_tick", mtime, 64'h0000_0001_0000_0001);

    // Shadow holds the pre-carry high half even though live has moved on
    regWrite(ADDR_MTIME_LO, 32'hFFFF_FFFF, 1'b0, 1'b0);
    regWrite(ADDR_MTIME_HI, 32'h0000_0000, 1'b0, 1'b0);
    regRead(ADDR_MTIME_LO, 32'hFFFF_FFFF, 1'b0);
    idleCycles(1, 1'b1);
    checkOutput("mt_carry2", mtime, 64'h0000_0001_0000_0000);
    regRead(ADDR_MTIME_HI, 32'h0000_0000, 1'b0);

    // Commit beats a coincident tick
    regWrite(ADDR_MTIME_LO, 32'h0000_0000, 1'b0, 1'b0);
    regWrite(ADDR_MTIME_HI, 32'h0000_0005, 1'b0, 1'b1);
    checkOutput("mt_commit_vs_tick", mtime, 64'h0000_0005_0000_0000);
    idleCycles(1, 1'b1);
    checkOutput("mt_tick_step1", mtime, 64'h0000_0005_0000_0001);
    regWrite(ADDR_CFG, 32'h0003_0000, 1'b0, 1'b0);
    idleCycles(1, 1'b1);
    checkOutput("mt_tick_step3", mtime, 64'h0000_0005_0000_0004);
    regWrite(ADDR_CTRL, 32'h0000_0000, 1'b0, 1'b0);
    idleCycles(2, 1'b1);
    checkOutput("mt_inactive", mtime, 64'h0000_0005_0000_0004);

    // Interrupt masking during a staged comparator write
    regWrite(ADDR_INTR_EN, 32'h0000_0001, 1'b0, 1'b0);
    checkOutput("intr_enabled", 64'(intr_o), 64'd1);
    regWrite(ADDR_CMP_BASE, 32'h0000_1000, 1'b0, 1'b0);
    checkOutput("intr_masked", 64'(intr_o), 64'd0);
    idleCycles(2, 1'b0);
    checkOutput("intr_masked_hold", 64'(intr_o), 64'd0);
    checkOutput("cmp_staged_hold", mtimecmp[0], 64'hFFFF_FFFF_FFFF_FFFF);
    regWrite(9'h104, 32'h0000_0002, 1'b0, 1'b0);
    checkOutput("cmp_commit", mtimecmp[0], 64'h0000_0002_0000_1000);
    checkOutput("intr_unmasked", 64'(intr_o), 64'd1);
    intr_raw = '0;
    #1;
    checkOutput("intr_follow_raw", 64'(intr_o), 64'd0);
    intr_raw = '1;
    regRead(ADDR_CMP_BASE, 32'h0000_1000, 1'b0);
    regRead(9'h104, 32'h0000_0002, 1'b0);

    // Another write in a staged state discards the stage
    regWrite(ADDR_CMP_BASE, 32'h0000_AAAA, 1'b0, 1'b0);
    regWrite(ADDR_INTR_EN, 32'h0000_0001, 1'b0, 1'b0);
    checkOutput("intr_discard", 64'(intr_o), 64'd1);
    regWrite(9'h104, 32'h0000_0003, 1'b0, 1'b0);
    checkOutput("cmp_discard", mtimecmp[0], 64'h0000_0003_0000_1000);

    // Illegal accesses
    regRead(9'h0FC, 32'd0, 1'b1);
    regWrite(9'h108, 32'h0000_1234, 1'b1, 1'b0);
    checkOutput("err_cmp_unchanged", mtimecmp[0], 64'h0000_0003_0000_1000);
    regRead(9'h108, 32'd0, 1'b1);
    regRead(9'h002, 32'd0, 1'b1);
    expQ.push_back('{rvalid: 1'b1, err: 1'b1, data: 32'd0, addr: ADDR_CTRL});
    applyStimulus(1'b1, 1'b1, ADDR_CTRL, 32'h0000_0001, 1'b0);
    checkOutput("err_we_re_active", 64'(active), 64'd0);
    regWrite(ADDR_MTIME_LO, 32'h0000_0011, 1'b0, 1'b0);
    regWrite(9'h108, 32'h0000_0005, 1'b1, 1'b0);
    regWrite(ADDR_MTIME_HI, 32'h0000_0022, 1'b0, 1'b0);
    checkOutput("err_keeps_stage", mtime, 64'h0000_0022_0000_0011);

    // Reset while staged and with a read in flight
    regWrite(ADDR_CFG, 32'h0005_0ABC, 1'b0, 1'b0);
    regWrite(ADDR_CTRL, 32'h0000_0001, 1'b0, 1'b0);
    regWrite(ADDR_MTIME_LO, 32'hDEAD_BEEF, 1'b0, 1'b0);
    rst_i = 1'b1;
    applyStimulus(1'b0, 1'b1, ADDR_MTIME_LO, 32'd0, 1'b0);
    rst_i = 1'b0;
    checkResetState();
    regWrite(ADDR_MTIME_HI, 32'h0000_0007, 1'b0, 1'b0);
    checkOutput("post_rst_commit", mtime, 64'h0000_0007_0000_0000);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 20 && expQ.size() != 0; k++) @(posedge clk_i);
    idleCycles(2, 1'b0);
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL rsp_timeout: got %0d outstanding responses, expected 0", expQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
